// File: rtl/jtkiwi_gfxrom_pkg.sv
// Shared definitions for the Kiwi graphics ROM bridge: FSM state encoding,
// client identifiers, cache tag width and a saturating counter helper.
package jtkiwi_gfxrom_pkg;

  localparam int TAGW = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  typedef enum logic {
    CL_SCR = 1'b0,
    CL_OBJ = 1'b1
  } client_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/jtkiwi_gfxrom_bridge_if.sv
// Bus bundle between the Kiwi gfx block, the ROM bridge and the SDRAM
// controller. The bridge uses the slave view (it answers the scr/obj fetch
// ports and issues SDRAM reads); the surrounding system uses the master view.
interface jtkiwi_gfxrom_bridge_if #(
  parameter int AW = 22
);

  logic [17:0]   scr_addr;
  logic          scr_cs;
  logic          scr_ok;
  logic [31:0]   scr_data;

  logic [17:0]   obj_addr;
  logic          obj_cs;
  logic          obj_ok;
  logic [31:0]   obj_data;

  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          sdram_dok;
  logic [31:0]   sdram_din;

  modport slave (
    input  scr_addr, scr_cs, obj_addr, obj_cs,
    input  sdram_ack, sdram_dok, sdram_din,
    output scr_ok, scr_data, obj_ok, obj_data,
    output sdram_req, sdram_addr
  );

  modport master (
    output scr_addr, scr_cs, obj_addr, obj_cs,
    output sdram_ack, sdram_dok, sdram_din,
    input  scr_ok, scr_data, obj_ok, obj_data,
    input  sdram_req, sdram_addr
  );

endinterface

// File: rtl/jtkiwi_gfxrom_cache.sv
// One-entry read cache for a single fetch client. Holds tag/data/valid,
// reports a combinational hit to the arbiter and presents a registered
// ok/data pair to the client.
module jtkiwi_gfxrom_cache
  import jtkiwi_gfxrom_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic [TAGW-1:0] addr,
  input  logic            inv,
  input  logic            fill,
  input  logic [TAGW-1:0] fill_tag,
  input  logic [31:0]     fill_data,
  output logic            hit,
  output logic            ok,
  output logic [31:0]     data
);

  logic [TAGW-1:0] tag;
  logic [31:0]     word;
  logic            valid;

  // Hit when the client is requesting and the stored line matches its address.
  always_comb begin
    hit = cs & valid & (addr == tag);
  end

  // Line storage: written by the bridge on a fill, cleared by reset/invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      word  <= 32'd0;
      valid <= 1'b0;
    end else if (inv) begin
      valid <= 1'b0;
    end else if (fill) begin
      tag   <= fill_tag;
      word  <= fill_data;
      valid <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  // Client outputs: ok follows the hit one cycle later; data only moves on a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok   <= 1'b0;
      data <= 32'd0;
    end else begin
      ok <= hit;
      if (hit) begin
        data <= word;
      end else begin
        data <= data;
      end
    end
  end

endmodule

// File: rtl/jtkiwi_gfxrom_bridge.sv
// Kiwi graphics ROM bridge. Each of the scroll and object fetch clients has a
// one-entry cache; misses are arbitrated round-robin onto a single SDRAM read
// port with at most one transaction outstanding. The client address gets a
// per-client word offset (wrapping modulo 2^AW) to form the SDRAM address.
// Optional build macro JTKIWI_GFXROM_STATS_EN adds per-client saturating
// miss counters (scr_miss_cnt, obj_miss_cnt).
module jtkiwi_gfxrom_bridge
  import jtkiwi_gfxrom_pkg::*;
#(
  parameter int            AW         = 22,
  parameter logic [AW-1:0] SCR_OFFSET = 22'h00000,
  parameter logic [AW-1:0] OBJ_OFFSET = 22'h40000
) (
  input  logic                   clk,
  input  logic                   rst,
  jtkiwi_gfxrom_bridge_if.slave  bus
`ifdef JTKIWI_GFXROM_STATS_EN
  ,
  output logic [15:0]            scr_miss_cnt,
  output logic [15:0]            obj_miss_cnt
`endif
);

  state_t          state;
  client_t         sel;
  client_t         rr;
  client_t         pick;
  logic [TAGW-1:0] req_tag;
  logic [31:0]     req_data;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;

  logic            scr_hit;
  logic            obj_hit;
  logic            scr_ok;
  logic            obj_ok;
  logic [31:0]     scr_data;
  logic [31:0]     obj_data;
  logic            scr_pend;
  logic            obj_pend;
  logic            any_pend;
  logic            fill_scr;
  logic            fill_obj;
  logic [TAGW-1:0] pick_addr;
  logic [AW-1:0]   pick_off;

  // Client word address plus bank offset, truncated to the SDRAM width.
  function automatic logic [AW-1:0] word_addr(input logic [TAGW-1:0] a,
                                              input logic [AW-1:0]   off);
    return AW'(a) + off;
  endfunction

  assign fill_scr = (state == ST_FILL) & (sel == CL_SCR);
  assign fill_obj = (state == ST_FILL) & (sel == CL_OBJ);

  jtkiwi_gfxrom_cache u_scr_cache (
    .clk       (clk),
    .rst       (rst),
    .cs        (bus.scr_cs),
    .addr      (bus.scr_addr),
    .inv       (1'b0),
    .fill      (fill_scr),
    .fill_tag  (req_tag),
    .fill_data (req_data),
    .hit       (scr_hit),
    .ok        (scr_ok),
    .data      (scr_data)
  );

  jtkiwi_gfxrom_cache u_obj_cache (
    .clk       (clk),
    .rst       (rst),
    .cs        (bus.obj_cs),
    .addr      (bus.obj_addr),
    .inv       (1'b0),
    .fill      (fill_obj),
    .fill_tag  (req_tag),
    .fill_data (req_data),
    .hit       (obj_hit),
    .ok        (obj_ok),
    .data      (obj_data)
  );

  assign bus.scr_ok     = scr_ok;
  assign bus.scr_data   = scr_data;
  assign bus.obj_ok     = obj_ok;
  assign bus.obj_data   = obj_data;
  assign bus.sdram_req  = sdram_req;
  assign bus.sdram_addr = sdram_addr;

  // Pending misses and round-robin choice; rr names the client preferred on a tie.
  always_comb begin
    scr_pend  = bus.scr_cs & ~scr_hit & ~((state != ST_IDLE) & (sel == CL_SCR));
    obj_pend  = bus.obj_cs & ~obj_hit & ~((state != ST_IDLE) & (sel == CL_OBJ));
    any_pend  = scr_pend | obj_pend;
    pick      = CL_SCR;
    if (scr_pend && obj_pend) begin
      pick = rr;
    end else if (obj_pend) begin
      pick = CL_OBJ;
    end else begin
      pick = CL_SCR;
    end
    if (pick == CL_OBJ) begin
      pick_addr = bus.obj_addr;
      pick_off  = OBJ_OFFSET;
    end else begin
      pick_addr = bus.scr_addr;
      pick_off  = SCR_OFFSET;
    end
  end

  // Miss service FSM: issue the SDRAM read, wait for data, fill the chosen cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= CL_SCR;
      rr         <= CL_SCR;
      req_tag    <= '0;
      req_data   <= 32'd0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_pend) begin
            sel        <= pick;
            req_tag    <= pick_addr;
            sdram_addr <= word_addr(pick_addr, pick_off);
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            sdram_req <= 1'b0;
            // Data may arrive together with the acknowledge.
            if (bus.sdram_dok) begin
              req_data <= bus.sdram_din;
              state    <= ST_FILL;
            end else begin
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.sdram_dok) begin
            req_data <= bus.sdram_din;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Next tie goes to the client that was not just served.
          rr    <= (sel == CL_SCR) ? CL_OBJ : CL_SCR;
          state <= ST_IDLE;
        end
        default: begin
          sdram_req <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JTKIWI_GFXROM_STATS_EN
  // Per-client miss counters, bumped once per completed fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      scr_miss_cnt <= 16'd0;
      obj_miss_cnt <= 16'd0;
    end else if (fill_scr) begin
      scr_miss_cnt <= sat_inc16(scr_miss_cnt);
    end else if (fill_obj) begin
      obj_miss_cnt <= sat_inc16(obj_miss_cnt);
    end else begin
      scr_miss_cnt <= scr_miss_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_jtkiwi_gfxrom_bridge.sv
// Self-checking bench for jtkiwi_gfxrom_bridge: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle against
// a transaction-level model of the caches and the single SDRAM read slot.
module tb_jtkiwi_gfxrom_bridge;

  localparam logic [21:0] OFF_SCR = 22'h00000;
  localparam logic [21:0] OFF_OBJ = 22'h40000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jtkiwi_gfxrom_bridge_if #(.AW(22)) bus ();

`ifdef JTKIWI_GFXROM_STATS_EN
  logic [15:0] scr_miss_cnt;
  logic [15:0] obj_miss_cnt;
`endif

  jtkiwi_gfxrom_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef JTKIWI_GFXROM_STATS_EN
    ,
    .scr_miss_cnt (scr_miss_cnt),
    .obj_miss_cnt (obj_miss_cnt)
`endif
  );

  // ---------------- behavioural model ----------------
  // Cache contents per client (0 = scr, 1 = obj)
  bit          m_v   [2];
  logic [17:0] m_tag [2];
  logic [31:0] m_dat [2];
  // Expected DUT outputs after the next clock edge
  bit          e_ok   [2];
  logic [31:0] e_data [2];
  bit          e_req;
  logic [21:0] e_addr;
  int          m_cnt  [2];
  // The single SDRAM transaction slot
  bit          busy, acked, filling;
  int          srv, last;
  logic [17:0] t_tag;
  logic [31:0] t_dat;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock using the inputs as they are right now.
  function automatic void model_step();
    bit          cs [2];
    logic [17:0] ad [2];
    bit          h  [2];
    bit          p  [2];
    logic [21:0] off;
    cs[0] = bus.scr_cs;  ad[0] = bus.scr_addr;
    cs[1] = bus.obj_cs;  ad[1] = bus.obj_addr;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_v[c] = 0; e_ok[c] = 0; e_data[c] = 32'd0; m_cnt[c] = 0;
      end
      e_req = 0; e_addr = 22'd0;
      busy = 0; acked = 0; filling = 0; last = 1;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      h[c]    = cs[c] && m_v[c] && (ad[c] == m_tag[c]);
      e_ok[c] = h[c];
      if (h[c]) e_data[c] = m_dat[c];
    end
    if (filling) begin
      m_v[srv] = 1; m_tag[srv] = t_tag; m_dat[srv] = t_dat;
      if (m_cnt[srv] < 65535) m_cnt[srv]++;
      last = srv; filling = 0; busy = 0;
    end else if (!busy) begin
      for (int c = 0; c < 2; c++) p[c] = cs[c] && !h[c];
      if (p[0] || p[1]) begin
        if (p[0] && p[1]) srv = 1 - last;
        else              srv = p[0] ? 0 : 1;
        off    = (srv == 0) ? OFF_SCR : OFF_OBJ;
        busy   = 1; acked = 0;
        t_tag  = ad[srv];
        e_req  = 1;
        e_addr = 22'({4'd0, ad[srv]} + off);
      end
    end else if (!acked) begin
      if (bus.sdram_ack) begin
        acked = 1; e_req = 0;
        if (bus.sdram_dok) begin t_dat = bus.sdram_din; filling = 1; end
      end
    end else if (bus.sdram_dok) begin
      t_dat = bus.sdram_din; filling = 1;
    end
  endfunction

  // Compare every DUT output against the model.
  function automatic void check_outputs();
    chk("scr_ok",    bus.scr_ok,    e_ok[0]);
    chk("obj_ok",    bus.obj_ok,    e_ok[1]);
    chk("scr_data",  bus.scr_data,  e_data[0]);
    chk("obj_data",  bus.obj_data,  e_data[1]);
    chk("sdram_req", bus.sdram_req, e_req);
    if (e_req) chk("sdram_addr", bus.sdram_addr, e_addr);
`ifdef JTKIWI_GFXROM_STATS_EN
    chk("scr_miss_cnt", scr_miss_cnt, m_cnt[0]);
    chk("obj_miss_cnt", obj_miss_cnt, m_cnt[1]);
`endif
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.scr_cs = 1'b0; bus.obj_cs = 1'b0;
    bus.sdram_ack = 1'b0; bus.sdram_dok = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm, input logic [21:0] exp_addr);
    int n = 0;
    while (!bus.sdram_req && n < 40) begin tick(); n++; end
    chk({nm, "_req"},  bus.sdram_req,  1'b1);
    chk({nm, "_addr"}, bus.sdram_addr, exp_addr);
  endtask

  // Acknowledge the pending request; data follows dly cycles after the ack.
  task automatic serve(input int dly, input logic [31:0] d);
    bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
    repeat (dly - 1) tick();
    bus.sdram_dok = 1'b1; bus.sdram_din = d; tick();
    bus.sdram_dok = 1'b0; bus.sdram_din = $urandom;
  endtask

  task automatic wait_ok(input string nm, input int c, input logic [31:0] d);
    int n = 0;
    while (((c == 0) ? !bus.scr_ok : !bus.obj_ok) && n < 10) begin tick(); n++; end
    chk({nm, "_ok"},   (c == 0) ? bus.scr_ok : bus.obj_ok, 1'b1);
    chk({nm, "_data"}, (c == 0) ? bus.scr_data : bus.obj_data, d);
  endtask

  initial begin
    logic [31:0] d0, d1;
    bit          awaiting;
    bus.scr_addr = 18'd0; bus.obj_addr = 18'd0;
    bus.scr_cs = 1'b0;    bus.obj_cs = 1'b0;
    bus.sdram_ack = 1'b0; bus.sdram_dok = 1'b0; bus.sdram_din = 32'd0;

    // Reset values
    do_reset();
    chk("rst_scr_ok",     bus.scr_ok,     1'b0);
    chk("rst_obj_ok",     bus.obj_ok,     1'b0);
    chk("rst_scr_data",   bus.scr_data,   32'd0);
    chk("rst_obj_data",   bus.obj_data,   32'd0);
    chk("rst_sdram_req",  bus.sdram_req,  1'b0);
    chk("rst_sdram_addr", bus.sdram_addr, 22'd0);

    // Cold miss, data four cycles after ack
    bus.scr_cs = 1'b1; bus.scr_addr = 18'h00010;
    tick();
    wait_req("cold", 22'h00010);
    serve(4, 32'hDEADBEEF);
    wait_ok("cold", 0, 32'hDEADBEEF);

    // Hit: ok stays, no new request; then an address change misses
    repeat (4) begin
      tick();
      chk("hit_ok",    bus.scr_ok,    1'b1);
      chk("hit_noreq", bus.sdram_req, 1'b0);
    end
    bus.scr_addr = 18'h00011;
    tick();
    chk("chg_ok_drop", bus.scr_ok,    1'b0);
    chk("chg_req",     bus.sdram_req, 1'b1);
    chk("chg_addr",    bus.sdram_addr, 22'h00011);
    serve(2, 32'h11112222);
    wait_ok("chg", 0, 32'h11112222);

    // Contention right after reset: scr first, then obj with its offset
    do_reset();
    bus.scr_cs = 1'b1; bus.scr_addr = 18'h00020;
    bus.obj_cs = 1'b1; bus.obj_addr = 18'h00030;
    tick();
    wait_req("cont_scr", 22'h00020);
    serve(3, 32'hA0A0A0A0);
    wait_req("cont_obj", 22'h40030);
    serve(1, 32'hB0B0B0B0);
    wait_ok("cont_obj", 1, 32'hB0B0B0B0);
    wait_ok("cont_scr", 0, 32'hA0A0A0A0);

    // Eight alternating miss pairs: both clients always get served
    for (int i = 0; i < 8; i++) begin
      d0 = $urandom; d1 = $urandom;
      bus.scr_addr = 18'h00100 + 18'(i);
      bus.obj_addr = 18'h00200 + 18'(i);
      tick();
      wait_req("pair_scr", 22'h00100 + 22'(i));
      serve(1 + i % 3, d0);
      wait_req("pair_obj", 22'h40200 + 22'(i));
      serve(1 + (i + 1) % 3, d1);
      wait_ok("pair_obj", 1, d1);
      wait_ok("pair_scr", 0, d0);
    end

    // Object address changes while its fetch is waiting for data
    bus.scr_cs = 1'b0;
    bus.obj_addr = 18'h00100;
    tick();
    wait_req("mid_first", 22'h40100);
    bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
    bus.obj_addr = 18'h00200;
    tick();
    bus.sdram_dok = 1'b1; bus.sdram_din = 32'h0BADF00D; tick(); bus.sdram_dok = 1'b0;
    tick();
    chk("mid_ok_low", bus.obj_ok, 1'b0);
    wait_req("mid_second", 22'h40200);
    chk("mid_ok_low2", bus.obj_ok, 1'b0);
    serve(2, 32'h5A5A5A5A);
    wait_ok("mid", 1, 32'h5A5A5A5A);

    // Reset while waiting for data, then a late data pulse
    bus.obj_cs = 1'b0;
    bus.scr_cs = 1'b1; bus.scr_addr = 18'h00300;
    tick();
    wait_req("rw_first", 22'h00300);
    bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
    rst = 1'b1; bus.scr_cs = 1'b0; tick(); rst = 1'b0;
    bus.sdram_dok = 1'b1; bus.sdram_din = 32'hFFFF0000; tick(); bus.sdram_dok = 1'b0;
    chk("rw_scr_ok", bus.scr_ok,    1'b0);
    chk("rw_obj_ok", bus.obj_ok,    1'b0);
    chk("rw_req",    bus.sdram_req, 1'b0);
    tick();
    chk("rw_scr_ok2", bus.scr_ok, 1'b0);
    bus.scr_cs = 1'b1;
    tick();
    wait_req("rw_again", 22'h00300);
    serve(1, 32'h300300AA);
    wait_ok("rw_again", 0, 32'h300300AA);

    // Randomized traffic, including stray ack/dok pulses and occasional reset
    awaiting = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 7) == 0)  bus.scr_addr = 18'h00400 + 18'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  bus.obj_addr = (($urandom_range(0, 1) == 0) ? 18'h3FFFC : 18'h00800)
                                                      + 18'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.scr_cs = ~bus.scr_cs;
      if ($urandom_range(0, 15) == 0) bus.obj_cs = ~bus.obj_cs;
      bus.sdram_din = $urandom;
      bus.sdram_ack = bus.sdram_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      bus.sdram_dok = awaiting ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      if (bus.sdram_dok) awaiting = 0;
      if (bus.sdram_req && bus.sdram_ack && !bus.sdram_dok) awaiting = 1;
      rst = ($urandom_range(0, 499) == 0);
      if (rst) awaiting = 0;
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
